// File: rtl/negate_serial_unit.sv
// Digit-serial pass / negate / absolute / ones' complement unit, DIGIT bits per cycle.
// Optional overflow flag port enabled by defining OVERFLOW_FLAG_EN.
module negate_serial_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             carry_q, carry_d;
  logic             inv_q, inv_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] dext;
  logic             last;
  logic             neg_a;

`ifdef OVERFLOW_FLAG_EN
  localparam logic [WIDTH-1:0] MNEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_q, ovf_d;
  logic mneg_q, mneg_d;
`endif

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    y_d     = y_q;
    carry_d = carry_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
    mneg_d  = mneg_q;
`endif

    neg_a = (mode == 2'b01) || ((mode == 2'b10) && A[WIDTH-1]);
    dsum  = {1'b0, opnd_q[DIGIT-1:0] ^ {DIGIT{inv_q}}} + {{DIGIT{1'b0}}, carry_q};
    // Sum digits enter at the top of res and walk down, so after NDIG shifts
    // the first (LSB) digit sits at bit 0.
    dext  = WIDTH'(dsum[DIGIT-1:0]);
    last  = (cnt_q == CW'(NDIG - 1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opnd_d  = A;
          inv_d   = neg_a || (mode == 2'b11);
          carry_d = neg_a;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef OVERFLOW_FLAG_EN
          mneg_d  = ((mode == 2'b01) || (mode == 2'b10)) && (A == MNEG);
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        opnd_d  = opnd_q >> DIGIT;
        res_d   = (res_q >> DIGIT) | (dext << (WIDTH - DIGIT));
        carry_d = dsum[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          y_d     = res_d;
          state_d = DONE;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = mneg_q;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      res_q   <= '0;
      y_q     <= '0;
      carry_q <= 1'b0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
      mneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      y_q     <= y_d;
      carry_q <= carry_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
      mneg_q  <= mneg_d;
`endif
    end
  end

  assign Y    = y_q;
  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
`ifdef OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: doc/negate_serial_unit.md
NEGATE_SERIAL_UNIT -- requirements
Module: negate_serial_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal values 4 or more).
REQ-002 The module SHALL have parameter DIGIT, default 1, meaning bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-005 The module SHALL have port start, input, 1, meaning a request to begin an operation.
REQ-006 The module SHALL have port mode, input, 2, meaning the operation: 00 pass, 01 negate (two's complement), 10 absolute value, 11 ones' complement.
REQ-007 The module SHALL have port A, input, WIDTH, meaning the operand, sampled only when start is accepted.
REQ-008 The module SHALL have port Y, output, WIDTH, meaning the registered result.
REQ-009 The module SHALL have port busy, output, 1, meaning high while digits are being processed.
REQ-010 The module SHALL have port done, output, 1, meaning a one-cycle completion pulse.
REQ-011 The module SHALL have port ovf, output, 1, meaning the overflow flag, present only under OVERFLOW_FLAG_EN (see Configuration).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 at an edge SHALL be accepted; that edge latches A and mode, loads carry (1 for negate, and for abs with A[WIDTH-1]=1; otherwise 0), clears digit counter, and enters SHIFT.
REQ-014 start in SHIFT or DONE SHALL be ignored, with no effect on state, operand or Y.
REQ-015 SHIFT: each edge SHALL process the next DIGIT bits, LSB digit first, as (operand digit, inverted when negating) plus carry, then update carry.
REQ-016 Pass, and abs of a non-negative operand, SHALL use no inversion with carry 0; ones' complement SHALL use inversion with carry 0.
REQ-017 SHIFT SHALL last exactly WIDTH/DIGIT edges; the final SHIFT edge writes the full result to Y and enters DONE.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle; the next edge returns to IDLE.
REQ-019 Latency SHALL be: start accepted at edge k -> Y valid and done=1 after edge k+WIDTH/DIGIT.
REQ-020 busy SHALL be 1 exactly while in SHIFT.
REQ-021 Y SHALL hold the previous result throughout SHIFT and SHALL change only on the final SHIFT edge.
REQ-022 Final carry-out SHALL be discarded; results SHALL be modulo 2^WIDTH.
REQ-023 Negate or abs of the most-negative value (1 followed by zeros) SHALL return that same value.
REQ-024 Negate of 0 SHALL return 0.
REQ-025 start held high continuously SHALL start a new operation on each IDLE visit, giving one result per WIDTH/DIGIT+2 cycles.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, Y=0, busy=0, done=0, ovf=0, carry=0 and counter=0.
REQ-027 Reset during SHIFT SHALL abort the operation, produce no done pulse, and leave Y=0.
REQ-028 After rst_n deasserts, the first start SHALL be accepted at the first rising edge.

Configuration
REQ-029 Macro OVERFLOW_FLAG_EN defined: port ovf SHALL exist, be set with the final SHIFT edge when mode is negate or abs and the operand is the most-negative value, hold with Y, and clear when the next start is accepted.
REQ-030 Macro OVERFLOW_FLAG_EN undefined: port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=8, DIGIT=1, mode=01, A=0x05 -> Y=0xFB, done pulse 8 cycles after the accepting edge, busy high for 8 cycles.
REQ-032 WIDTH=8, mode=01, A=0x80 -> Y=0x80, ovf=1 (macro on); mode=01, A=0x00 -> Y=0x00, ovf=0.
REQ-033 WIDTH=8, mode=10, A=0xF6 -> Y=0x0A; mode=10, A=0x0A -> Y=0x0A; mode=11, A=0x0F -> Y=0xF0; mode=00, A=0x3C -> Y=0x3C.
REQ-034 WIDTH=16, DIGIT=4, mode=01, A=0x1234 -> Y=0xEDCC, done 4 cycles after the accepting edge.
REQ-035 start pulsed again during SHIFT with different A -> ignored, and the first operation's result is correct.
REQ-036 rst_n low for 1 cycle mid-SHIFT -> IDLE, Y=0, no done; a new start then completes normally.
